// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer front-end.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/multi_barrel_shifter_mux.sv
// Logical barrel shifter built from log2(width) mux stages; zero fill, lr selects direction.
module multi_barrel_shifter_mux
  import shift_seq_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2**N-1:0] a,
  input  logic [N-1:0]    amt,
  input  logic            lr,
  output logic [2**N-1:0] y
);

  logic [2**N-1:0] stage [N+1];

  assign stage[0] = a;

  for (genvar i = 0; i < N; i++) begin : g_stage
    logic [2**N-1:0] shifted;
    assign shifted = (lr == SHIFT_RIGHT) ? (stage[i] >> (2**i)) : (stage[i] << (2**i));
    assign stage[i+1] = amt[i] ? shifted : stage[i];
  end

  assign y = stage[N];

endmodule

// File: rtl/shift_sequencer.sv
// Loads a word, applies a stream of shift commands to it, and pulses done on last/budget/abort.
// Optional macro SHIFT_SEQ_ZERO_EXIT_EN adds a registered zero flag and ends a sequence on a zero result.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N       = 3,
  parameter int MAX_OPS = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [2**N-1:0]              data_in,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [N-1:0]                 cmd_amt,
  input  logic                         cmd_lr,
  input  logic                         cmd_last,
  input  logic                         abort,
  output logic [2**N-1:0]              y,
  output logic                         busy,
  output logic                         done,
  output logic                         ovf,
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
  output logic                         zero,
`endif
  output logic [$clog2(MAX_OPS+1)-1:0] op_cnt
);

  localparam int CW = $clog2(MAX_OPS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_OPS - 1);
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
  localparam logic ZERO_EXIT = 1'b1;
`else
  localparam logic ZERO_EXIT = 1'b0;
`endif

  state_t          state;
  logic [2**N-1:0] acc;
  logic [2**N-1:0] shifted;
  logic            accept;
  logic            res_zero;

  multi_barrel_shifter_mux #(.N(N)) u_shifter (
    .a   (acc),
    .amt (cmd_amt),
    .lr  (cmd_lr),
    .y   (shifted)
  );

  assign cmd_ready = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign accept    = cmd_valid && cmd_ready && !abort;
  assign res_zero  = (shifted == '0);
  assign y         = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      op_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= data_in;
            op_cnt <= '0;
            ovf    <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          // abort wins over a same-cycle command; accept already excludes it
          if (abort) begin
            state <= DONE;
          end else if (accept) begin
            acc    <= shifted;
            op_cnt <= op_cnt + 1'b1;
            if (cmd_last) begin
              state <= DONE;
            end else if (ZERO_EXIT && res_zero) begin
              state <= DONE;
            end else if (op_cnt == LAST_CNT) begin
              ovf   <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_SEQ_ZERO_EXIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
    end else if (state == IDLE && start) begin
      zero <= (data_in == '0);
    end else if (accept) begin
      zero <= res_zero;
    end
  end
`else
  logic unused_zero;
  assign unused_zero = res_zero;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (N=3, MAX_OPS=8); honours SHIFT_SEQ_ZERO_EXIT_EN.
module tb_shift_sequencer;

  localparam int N       = 3;
  localparam int MAX_OPS = 8;
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
  localparam bit ZEXIT = 1'b1;
`else
  localparam bit ZEXIT = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       cmd_valid = 1'b0, cmd_lr = 1'b0, cmd_last = 1'b0, abort = 1'b0;
  logic [7:0] data_in = '0;
  logic [2:0] cmd_amt = '0;
  logic       cmd_ready, busy, done, ovf;
  logic [7:0] y;
  logic [3:0] op_cnt;
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
  logic       zero;
`endif

  typedef struct {
    logic [7:0] y;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_checks = 0, n_pass = 0;
  logic [7:0]  m_acc;
  logic [3:0]  m_cnt;
  logic        m_ovf;
  bit          ended;

  shift_sequencer #(.N(N), .MAX_OPS(MAX_OPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .data_in   (data_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_amt   (cmd_amt),
    .cmd_lr    (cmd_lr),
    .cmd_last  (cmd_last),
    .abort     (abort),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
    .zero      (zero),
`endif
    .op_cnt    (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Completion monitor: every done pulse retires one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'(done), 0);
      end else begin
        e = sbq.pop_front();
        check("sb_y", 32'(y), 32'(e.y));
        check("sb_cnt", 32'(op_cnt), 32'(e.cnt));
        check("sb_ovf", 32'(ovf), 32'(e.ovf));
        check("sb_ready", 32'(cmd_ready), 0);
        check("sb_busy", 32'(busy), 1);
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
        check("sb_zero", 32'(zero), 32'(e.y == 8'h00));
`endif
      end
    end
  end

  task automatic do_start(input logic [7:0] d);
    start = 1'b1; data_in = d;
    @(negedge clk);
    start = 1'b0;
    m_acc = d; m_cnt = '0; m_ovf = 1'b0;
    check("start_y", 32'(y), 32'(d));
    check("start_busy", 32'(busy), 1);
    check("start_ready", 32'(cmd_ready), 1);
    check("start_cnt", 32'(op_cnt), 0);
    check("start_ovf", 32'(ovf), 0);
  endtask

  task automatic send_cmd(input logic [2:0] amt, input logic lr, input logic last, output bit fin);
    cmd_valid = 1'b1; cmd_amt = amt; cmd_lr = lr; cmd_last = last;
    m_acc = lr ? (m_acc >> amt) : (m_acc << amt);
    m_cnt = m_cnt + 4'd1;
    fin = 1'b0;
    if (last) fin = 1'b1;
    else if (ZEXIT && m_acc == 8'h00) fin = 1'b1;
    else if (int'(m_cnt) == MAX_OPS) begin m_ovf = 1'b1; fin = 1'b1; end
    if (fin) sbq.push_back('{y: m_acc, cnt: m_cnt, ovf: m_ovf});
    @(negedge clk);
    cmd_valid = 1'b0; cmd_last = 1'b0;
    check("cmd_y", 32'(y), 32'(m_acc));
    check("cmd_cnt", 32'(op_cnt), 32'(m_cnt));
    check("cmd_done", 32'(done), 32'(fin));
  endtask

  task automatic do_abort(input logic [2:0] amt, input logic lr);
    abort = 1'b1; cmd_valid = 1'b1; cmd_amt = amt; cmd_lr = lr;
    sbq.push_back('{y: m_acc, cnt: m_cnt, ovf: m_ovf});
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    check("abort_done", 32'(done), 1);
    check("abort_y", 32'(y), 32'(m_acc));
  endtask

  task automatic idle_after();
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_y", 32'(y), 32'(m_acc));
    check("idle_cnt", 32'(op_cnt), 32'(m_cnt));
  endtask

  initial begin
    int k, len;
    @(negedge clk);
    check("rst_y", 32'(y), 0);
    check("rst_cnt", 32'(op_cnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
    check("rst_zero", 32'(zero), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    do_start(8'b1011_0001);
    send_cmd(3'd2, 1'b0, 1'b1, ended);
    check("single_y", 32'(y), 32'(8'b1100_0100));
    idle_after();

    do_start(8'hF0);
    send_cmd(3'd4, 1'b1, 1'b0, ended);
    send_cmd(3'd1, 1'b0, 1'b1, ended);
    check("chain_y", 32'(y), 32'h1E);
    check("chain_cnt", 32'(op_cnt), 2);
    idle_after();

    do_start(8'h01);
    for (int i = 0; i < MAX_OPS; i++) begin
      send_cmd(3'd0, 1'b0, 1'b0, ended);
      if (i < MAX_OPS - 1) check("budget_early_ovf", 32'(ovf), 0);
    end
    check("budget_ovf", 32'(ovf), 1);
    check("budget_cnt", 32'(op_cnt), 8);
    check("budget_ready", 32'(cmd_ready), 0);
    idle_after();
    check("ovf_sticky", 32'(ovf), 1);

    do_start(8'h80);
    send_cmd(3'd0, 1'b0, 1'b0, ended);
    start = 1'b1; data_in = 8'h55;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_y", 32'(y), 32'h80);
    check("busy_start_cnt", 32'(op_cnt), 1);
    do_abort(3'd3, 1'b1);
    check("abort_cnt", 32'(op_cnt), 1);
    check("abort_ovf", 32'(ovf), 0);
    idle_after();

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 0);
    check("idle_abort_done", 32'(done), 0);

    do_start(8'h0F);
    send_cmd(3'd4, 1'b1, 1'b0, ended);
`ifdef SHIFT_SEQ_ZERO_EXIT_EN
    check("zexit_zero", 32'(zero), 1);
    check("zexit_y", 32'(y), 0);
    check("zexit_cnt", 32'(op_cnt), 1);
`endif
    if (!ended) begin
      check("nozexit_busy", 32'(busy), 1);
      send_cmd(3'd1, 1'b0, 1'b1, ended);
    end
    idle_after();

    do_start(8'h3C);
    send_cmd(3'd1, 1'b0, 1'b0, ended);
    send_cmd(3'd1, 1'b0, 1'b0, ended);
    #2 rst_n = 1'b0;
    #1;
    check("arst_y", 32'(y), 0);
    check("arst_cnt", 32'(op_cnt), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 6; s++) begin
      len = int'($urandom_range(1, 10));
      do_start(8'($urandom));
      k = 0;
      ended = 1'b0;
      while (!ended && k < 20) begin
        send_cmd(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), (k == len - 1), ended);
        k++;
      end
      check("rand_ended", 32'(ended), 1);
      idle_after();
    end

    check("sb_empty", 32'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Sequential front-end stage that feeds the existing `multi_barrel_shifter_mux` datapath.
- Loads one data word into an accumulator register, then applies a stream of shift commands (amount + direction) one per accepted handshake.
- Each command routes the accumulator through the shifter and writes the result back into the accumulator.
- Signals completion when the last command retires, on overflow of the op budget, or on abort.

Parameters:
- N, 3, log2 of data width; data is 2**N bits, shift amount is N bits.
- MAX_OPS, 8, maximum commands per sequence before forced termination (>=1).

Ports:
- clk, input, 1, single system clock, rising edge.
- rst_n, input, 1, reset, asynchronous assert, active-low.
- start, input, 1, begin sequence; sampled only in IDLE.
- data_in, input, 2**N, initial accumulator value, captured with start.
- cmd_valid, input, 1, command present.
- cmd_ready, output, 1, block accepts command this cycle.
- cmd_amt, input, N, shift amount 0..2**N-1.
- cmd_lr, input, 1, 0 = left, 1 = right.
- cmd_last, input, 1, final command of sequence.
- abort, input, 1, terminate sequence early.
- y, output, 2**N, accumulator value (registered).
- busy, output, 1, high in RUN and DONE.
- done, output, 1, one-cycle completion pulse.
- ovf, output, 1, sticky: sequence hit MAX_OPS without cmd_last.
- op_cnt, output, $clog2(MAX_OPS+1), commands applied in current or last sequence.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, y=0, op_cnt=0, done=0, ovf=0, cmd_ready=0, busy=0. Any sequence in progress is discarded.
- States:
  - IDLE: cmd_ready=0, busy=0. On start: acc<=data_in, op_cnt<=0, ovf<=0, go to RUN. start is ignored in every other state.
  - RUN: cmd_ready=1. An accept is cmd_valid & cmd_ready.
    - On accept: acc<=shift(acc, cmd_amt, cmd_lr), op_cnt<=op_cnt+1.
    - If cmd_last: go to DONE.
    - Else if op_cnt+1==MAX_OPS: ovf<=1, go to DONE.
  - DONE: done=1 for exactly this one cycle, cmd_ready=0. Unconditionally go to IDLE next cycle.
- Shift semantics: logical; vacated bits are zero-filled. Amount 0 leaves acc unchanged but still counts as an op. Shift result is combinational from acc; write-back latency is 1 cycle per command.
- Timing:
  - start at cycle t: y=data_in at t+1.
  - Command accepted at t: new y visible at t+1.
  - Last command accepted at t: done=1 at t+1, IDLE at t+2.
- abort:
  - In RUN: takes priority over a same-cycle accept. The command is not applied, acc holds, go to DONE with ovf unchanged.
  - In IDLE or DONE: ignored.
- Simultaneous cmd_last and op budget reached: treat as normal last, ovf stays 0.
- y and op_cnt hold their values in IDLE until the next start.

Optional Feature:
- Macro SHIFT_SEQ_ZERO_EXIT_EN.
- Defined:
  - Adds output `zero` (1 bit) = (y==0), registered alongside y, reset 0.
  - In RUN, an accepted command whose result is 0 ends the sequence (go to DONE) even without cmd_last. ovf stays 0.
- Undefined: no `zero` port; zero results do not affect sequencing.

Decomposition:
- Package shift_seq_pkg:
  - State enum: IDLE, RUN, DONE.
  - Direction constants: SHIFT_LEFT=1'b0, SHIFT_RIGHT=1'b1.
- Datapath: one instance of `multi_barrel_shifter_mux` #(.N(N)), with a = acc, amt = cmd_amt, lr = cmd_lr. Its output feeds the acc write-back mux.
- FSM, counter and flags stay in this module; no further sub-modules.

Test Plan (N=3, MAX_OPS=8):
- Single left shift: start with data_in=8'b1011_0001, then one command amt=2, lr=0, last=1. Expect y=8'b1100_0100, done pulse one cycle after accept, op_cnt=1, ovf=0.
- Chained shifts: data_in=8'hF0, then right 4 followed by left 1 (last). Expect y=8'h1E, op_cnt=2, done exactly once.
- Budget exhaustion: data_in=8'h01, then 8 commands of left 0 with last=0. Expect DONE after the 8th accept, ovf=1, op_cnt=8, y=8'h01, cmd_ready=0 in DONE.
- Abort priority: in RUN, drive abort=1 together with cmd_valid=1 (amt=3, lr=1, data 8'h80). Expect y stays 8'h80, op_cnt unchanged, done next cycle.
- Reset mid-sequence: after 2 accepts, pulse rst_n low asynchronously between clock edges. Expect y=0, op_cnt=0, state IDLE immediately. A start issued while busy must be ignored.
- With SHIFT_SEQ_ZERO_EXIT_EN defined: data 8'h0F, then right 4 with last=0. Expect y=0, zero=1, done pulse, op_cnt=1.
